// File: rtl/fifo_lzc_unit.sv
// -----------------------------------------------------------------------------
// fifo_lzc_unit
//
// Storage-and-arbitration primitive for the fetch front-end: a synchronous
// FIFO plus an independent, purely combinational trailing/leading-zero counter.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   DATA_WIDTH   FIFO word width
//   FALL_THROUGH 1 = an empty FIFO forwards data_i to data_o combinationally
//   LZC_WIDTH    zero-counter input width (>= 1)
//   LZC_MODE     0 = count trailing zeros, 1 = count leading zeros
//
// Ports:
//   clk_i, rst_ni (async, active-low)     clock / reset
//   flush_i                               synchronous clear of pointers/count
//   testmode_i                            DFT bypass, no functional effect
//   push_i, data_i                        write request and data
//   pop_i                                 consume head entry
//   data_o                                head entry (stale when empty)
//   full_o, empty_o, usage_o              status (usage is count mod DEPTH)
//   lzc_in_i, lzc_cnt_o, lzc_empty_o      zero counter
//
// Optional build macro:
//   FIFO_ASSERT_EN  compiles in simulation assertions for overflow,
//                   underflow and illegal parameters.
// -----------------------------------------------------------------------------
module fifo_lzc_unit #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FALL_THROUGH = 0,
    parameter int unsigned LZC_WIDTH    = 4,
    parameter int unsigned LZC_MODE     = 0
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              flush_i,
    input  logic                                              testmode_i,
    input  logic                                              push_i,
    input  logic [DATA_WIDTH-1:0]                             data_i,
    input  logic                                              pop_i,
    output logic [DATA_WIDTH-1:0]                             data_o,
    output logic                                              full_o,
    output logic                                              empty_o,
    output logic [$clog2(DEPTH)-1:0]                          usage_o,
    input  logic [LZC_WIDTH-1:0]                              lzc_in_i,
    output logic [((LZC_WIDTH > 1) ? $clog2(LZC_WIDTH) : 1)-1:0] lzc_cnt_o,
    output logic                                              lzc_empty_o
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LCW = (LZC_WIDTH > 1) ? $clog2(LZC_WIDTH) : 1;
    localparam int unsigned P   = 1 << LCW;  // zero-counter input padded to a power of two

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_rptr;
    logic [AW-1:0]         r_wptr;
    logic [AW:0]           r_count;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_push_acc;
    logic w_pop_acc;
    logic w_unused;

    assign w_unused = testmode_i;

    assign w_full  = (r_count == (AW + 1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // Handshake: a push is accepted when push_i is high and the FIFO is not
    // full; a pop is accepted when pop_i is high and the FIFO is not empty.
    // Requests that are not accepted are dropped without any state change.
    // In fall-through mode an empty FIFO with push and pop together hands the
    // word straight through, so nothing is written.
    assign w_bypass   = (FALL_THROUGH != 0) && w_empty && push_i;
    assign w_push_acc = push_i && !w_full && !(w_bypass && pop_i);
    assign w_pop_acc  = pop_i && !w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            // Memory is intentionally left untouched on flush.
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_acc) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push_acc && !w_pop_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign data_o  = w_bypass ? data_i : r_mem[r_rptr];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign usage_o = r_count[AW-1:0];

    // ------------------------------------------------------------------------
    // Zero counter: both modes reduce to "index of lowest set bit" by bit-
    // reversing the input for leading-zero mode. A binary tree combines pairs
    // of nodes per level; the lower half wins when it has a set bit, otherwise
    // the upper half's index gets this level's bit set.
    // ------------------------------------------------------------------------
    logic [P-1:0]                    w_scan;
    logic [LCW:0][P-1:0]             w_v;
    logic [LCW:0][P-1:0][LCW-1:0]    w_idx;

    always_comb begin
        w_scan = '0;
        for (int i = 0; i < int'(LZC_WIDTH); i++) begin
            w_scan[i] = (LZC_MODE != 0) ? lzc_in_i[int'(LZC_WIDTH) - 1 - i] : lzc_in_i[i];
        end
    end

    always_comb begin
        w_v    = '0;
        w_idx  = '0;
        w_v[0] = w_scan;
        for (int l = 0; l < int'(LCW); l++) begin
            for (int n = 0; n < (int'(P) >> (l + 1)); n++) begin
                w_v[l+1][n]   = w_v[l][2*n] | w_v[l][2*n+1];
                w_idx[l+1][n] = w_v[l][2*n] ? w_idx[l][2*n]
                                            : (w_idx[l][2*n+1] | LCW'(1 << l));
            end
        end
    end

    assign lzc_empty_o = ~w_v[LCW][0];
    assign lzc_cnt_o   = lzc_empty_o ? '0 : w_idx[LCW][0];

`ifdef FIFO_ASSERT_EN
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o)) else $error("fifo_lzc_unit: push while full");
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && empty_o)) else $error("fifo_lzc_unit: pop while empty");
    a_depth_legal: assert property (@(posedge clk_i)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0))
        else $error("fifo_lzc_unit: DEPTH must be a power of two >= 2");
    a_lzc_width_legal: assert property (@(posedge clk_i)
        LZC_WIDTH != 0) else $error("fifo_lzc_unit: LZC_WIDTH must be >= 1");
`endif

endmodule

// File: tb/tb_fifo_lzc_unit.sv
module tb_fifo_lzc_unit;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        testmode;

  // main instance: DEPTH=8, FALL_THROUGH=0, trailing-zero counter
  logic        flush, push, pop;
  logic [31:0] din;
  logic [3:0]  lzc_in;
  wire  [31:0] dout;
  wire         full, empty;
  wire  [2:0]  usage;
  wire  [1:0]  lzc_cnt;
  wire         lzc_empty;

  // fall-through instance with leading-zero counter
  logic        ft_flush, ft_push, ft_pop;
  logic [31:0] ft_din;
  wire  [31:0] ft_dout;
  wire         ft_full, ft_empty;
  wire  [2:0]  ft_usage;
  wire  [1:0]  ft_lzc_cnt;
  wire         ft_lzc_empty;

  // single-bit zero counter instance
  logic        lz1_in;
  wire  [31:0] lz1_dout;
  wire         lz1_full, lz1_empty_f;
  wire  [2:0]  lz1_usage;
  wire         lz1_cnt;
  wire         lz1_empty;

  fifo_lzc_unit u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
    .push_i(push), .data_i(din), .pop_i(pop), .data_o(dout),
    .full_o(full), .empty_o(empty), .usage_o(usage),
    .lzc_in_i(lzc_in), .lzc_cnt_o(lzc_cnt), .lzc_empty_o(lzc_empty)
  );

  fifo_lzc_unit #(.FALL_THROUGH(1), .LZC_MODE(1)) u_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(ft_flush), .testmode_i(testmode),
    .push_i(ft_push), .data_i(ft_din), .pop_i(ft_pop), .data_o(ft_dout),
    .full_o(ft_full), .empty_o(ft_empty), .usage_o(ft_usage),
    .lzc_in_i(lzc_in), .lzc_cnt_o(ft_lzc_cnt), .lzc_empty_o(ft_lzc_empty)
  );

  fifo_lzc_unit #(.LZC_WIDTH(1)) u_lz1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .testmode_i(testmode),
    .push_i(1'b0), .data_i(32'h0), .pop_i(1'b0), .data_o(lz1_dout),
    .full_o(lz1_full), .empty_o(lz1_empty_f), .usage_o(lz1_usage),
    .lzc_in_i(lz1_in), .lzc_cnt_o(lz1_cnt), .lzc_empty_o(lz1_empty)
  );

  // ---------------------------------------------------------------- scoreboard
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, "_full"},  32'(full),  32'(exp_q.size() == 8));
    check({tag, "_usage"}, 32'(usage), 32'(exp_q.size() % 8));
    if (exp_q.size() != 0) check({tag, "_head"}, dout, exp_q[0]);
  endtask

  // ---------------------------------------------------------------- drivers
  // Called at a negedge: applies one cycle of stimulus, updates the expected
  // queue at the posedge, returns at the following negedge with inputs idle.
  task automatic drive(input logic p, input logic [31:0] d, input logic q, input logic f);
    int sz;
    push = p; din = d; pop = q; flush = f;
    @(posedge clk);
    sz = exp_q.size();
    if (f) begin
      exp_q.delete();
    end else begin
      if (q && sz != 0) void'(exp_q.pop_front());
      if (p && sz != 8) exp_q.push_back(d);
    end
    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0; din = '0;
  endtask

  logic [31:0] seq5 [8];

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n = 1'b0; testmode = 1'b0;
    flush = 0; push = 0; pop = 0; din = '0; lzc_in = '0;
    ft_flush = 0; ft_push = 0; ft_pop = 0; ft_din = '0; lz1_in = 1'b0;
    seq5 = '{32'hB0, 32'hB1, 32'hB2, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4};

    repeat (2) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_usage", 32'(usage), 32'd0);
    check("rst_data",  dout,       32'd0);
    check("rst_ft_data", ft_dout,  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // fill with A0..A7
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    check("fill_full",  32'(full),  32'd1);
    check("fill_usage", 32'(usage), 32'd0);
    check_model("fill");
    drive(1'b1, 32'hFF, 1'b0, 1'b0);   // dropped
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_head", dout, 32'hA0);
    for (int i = 0; i < 8; i++) begin
      check("drain_head", dout, 32'hA0 + 32'(i));
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    drive(1'b0, '0, 1'b1, 1'b0);       // underflow ignored
    check_model("udf");

    // steady-state push+pop across pointer wrap
    for (int i = 0; i < 3; i++) drive(1'b1, seq5[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("pp_head",  dout, seq5[i]);
      check("pp_usage", 32'(usage), 32'd3);
      drive(1'b1, seq5[3+i], 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      check("pp_tail", dout, seq5[5+i]);
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    check_model("pp_end");

    // full with push+pop: only the pop happens
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'hE0, 1'b1, 1'b0);
    check("fpp_usage", 32'(usage), 32'd7);
    check("fpp_full",  32'(full),  32'd0);
    for (int i = 1; i < 8; i++) begin
      check("fpp_head", dout, 32'hD0 + 32'(i));
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    check("fpp_empty", 32'(empty), 32'd1);

    // flush overrides push
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0);
    check("pre_flush_usage", 32'(usage), 32'd5);
    drive(1'b1, 32'hF0, 1'b0, 1'b1);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_usage", 32'(usage), 32'd0);
    check("flush_full",  32'(full),  32'd0);
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    check("post_flush_head",  dout, 32'h11);
    check("post_flush_usage", 32'(usage), 32'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    check_model("post_flush");

    // fall-through: empty with push+pop passes the word and writes nothing
    ft_push = 1'b1; ft_pop = 1'b1; ft_din = 32'h55;
    #1;
    check("ft_bypass_data",  ft_dout, 32'h55);
    check("ft_bypass_empty", 32'(ft_empty), 32'd1);
    @(posedge clk); @(negedge clk);
    ft_push = 1'b0; ft_pop = 1'b0; ft_din = '0;
    check("ft_after_empty", 32'(ft_empty), 32'd1);
    check("ft_after_usage", 32'(ft_usage), 32'd0);
    // fall-through: empty with push only shows the word now and stores it
    ft_push = 1'b1; ft_din = 32'h66;
    #1;
    check("ft_push_data", ft_dout, 32'h66);
    @(posedge clk); @(negedge clk);
    ft_push = 1'b0; ft_din = '0;
    check("ft_stored_empty", 32'(ft_empty), 32'd0);
    check("ft_stored_data",  ft_dout, 32'h66);
    check("ft_stored_usage", 32'(ft_usage), 32'd1);

    // zero counters
    lzc_in = 4'b0110; lz1_in = 1'b1; #1;
    check("tz_0110", 32'(lzc_cnt), 32'd1);
    check("lz_0110", 32'(ft_lzc_cnt), 32'd1);
    check("tz_0110_e", 32'(lzc_empty), 32'd0);
    check("lz1_1_cnt", 32'(lz1_cnt), 32'd0);
    check("lz1_1_e", 32'(lz1_empty), 32'd0);
    lzc_in = 4'b1000; lz1_in = 1'b0; #1;
    check("tz_1000", 32'(lzc_cnt), 32'd3);
    check("lz_1000", 32'(ft_lzc_cnt), 32'd0);
    check("lz1_0_e", 32'(lz1_empty), 32'd1);
    lzc_in = 4'b0001; #1;
    check("tz_0001", 32'(lzc_cnt), 32'd0);
    check("lz_0001", 32'(ft_lzc_cnt), 32'd3);
    lzc_in = 4'b0000; #1;
    check("tz_0000_e", 32'(lzc_empty), 32'd1);
    check("tz_0000",   32'(lzc_cnt), 32'd0);
    check("lz_0000_e", 32'(ft_lzc_empty), 32'd1);
    check("lz_0000",   32'(ft_lzc_cnt), 32'd0);
    @(negedge clk);

    // asynchronous reset mid-operation
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    drive(1'b1, 32'h78, 1'b0, 1'b0);
    check("mid_usage", 32'(usage), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_usage", 32'(usage), 32'd0);
    check("arst_data",  dout, 32'd0);
    check("arst_ft_empty", 32'(ft_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model("post_arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
